mdu_iterative: RTL
==================

Name: mdu_iterative

Overview:
- Iterative multiply/divide unit for the MIPS data path.
- Executes MULTU, MULT, DIVU and DIV on NBIT-bit operands and produces HI/LO results.
- Uses a Start/Busy/Done handshake and a real multi-cycle datapath; the multiplier retires BITS_PER_CYCLE bits per cycle, the divider 1 bit per cycle.
- Sits beside the ALU; the EX-stage control stalls on Busy and writes HI/LO on the Done pulse.

Parameters:
- NBIT, 32: operand width; must be even and >= 8.
- BITS_PER_CYCLE, 2: multiplier bits retired per CALC cycle; allowed values 1, 2 or 4; NBIT must be a multiple of it.

Ports:
- Clk  input  1  clock; all state changes on the rising edge.
- Reset_n  input  1  reset; asynchronous, active-low.
- Start  input  1  request; sampled only when the unit is idle.
- Op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- MA  input  NBIT  multiplicand / dividend.
- MB  input  NBIT  multiplier / divisor.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse; Hi/Lo valid.
- Hi  output  NBIT  product upper half, or remainder.
- Lo  output  NBIT  product lower half, or quotient.

Behaviour:
- Reset (Reset_n low, any cycle, including mid-operation): state IDLE, Busy=0, Done=0, Hi=0, Lo=0, all internal registers cleared. The operation in flight is discarded. Leaving reset requires no Start re-arm.
- States are IDLE, CALC, FIX and DONE.
- IDLE: Start=1 at edge k latches Op, MA and MB, forms unsigned magnitudes and the result sign, then moves to CALC. Busy=1 from edge k.
  - Signed ops use NBIT-bit unsigned magnitudes, so |MIN| = 2^(NBIT-1) is exact.
  - Unsigned ops take the operands as is.
- Iteration count ITER: multiply = NBIT/BITS_PER_CYCLE; divide = NBIT (restoring, 1 quotient bit per cycle).
- CALC: one iteration per cycle, driven by a down-counter. Leave for FIX after ITER cycles.
- Divide by zero (MB==0 on a divide op) is detected at Start and goes IDLE -> FIX directly, with no CALC cycles.
- FIX: one cycle. Applies two's-complement negation where needed and loads Hi/Lo.
  - Signed multiply: the 2*NBIT product is negated if MA[NBIT-1]^MB[NBIT-1].
  - Signed divide: the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend.
  - Divide by zero: Lo = all ones, Hi = MA unchanged, for both DIV and DIVU.
  - Overflow case MIN / -1: Lo = MIN, Hi = 0, which falls out of truncation naturally and needs no special path.
- DONE: Done=1 and Busy=0 for exactly one cycle, then back to IDLE.
  - A Start in the DONE cycle is accepted, giving back-to-back operation.
  - Hi/Lo hold until the FIX of the next accepted operation.
- Latency, with Start accepted at edge k:
  - Done is high in the cycle following edge k+ITER+2.
  - Multiply with defaults: k+18. Divide: k+34. Divide by zero: k+2.
- Start while Busy=1 is ignored. MA, MB and Op may change freely after acceptance.
- Op values are all defined; there is no illegal encoding.

Optional Feature:
- Macro MDU_EARLY_OUT_EN.
- Defined: in CALC for multiply ops only, once the not-yet-consumed multiplier magnitude bits are all zero, go to FIX on the next edge. At least one CALC cycle is always spent. Latency becomes variable: Done at k+2+(iterations actually executed). Divide latency is unchanged.
- Undefined: fixed latency as above. The early-out zero-detect logic is not synthesised.

Decomposition:
- Package mdu_pkg holds:
  - the Op encoding constants (OP_MULTU, OP_MULT, OP_DIVU, OP_DIV);
  - the state encoding (IDLE, CALC, FIX, DONE);
  - the functions ITER_MUL(NBIT, BITS_PER_CYCLE) and ITER_DIV(NBIT).
- One sub-module, mdu_neg: a parametrised conditional two's-complement negate (width, enable). It is instantiated for the operand magnitudes at Start and for the result correction in FIX.

Test Plan:
- Unsigned multiply: MULTU MA=0xFFFFFFFF, MB=0xFFFFFFFF, defaults, no macro -> Hi=0xFFFFFFFE, Lo=0x00000001; Done exactly at k+18; Busy high k..k+17.
- Signed multiply: MULT MA=0xFFFFFFFD (-3), MB=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1. Also MULT MIN*MIN -> Hi=0x40000000, Lo=0.
- Signed divide: DIV MA=0xFFFFFFF9 (-7), MB=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; Done at k+34. Also DIV 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- Divide by zero: DIVU MA=100, MB=0 -> Lo=0xFFFFFFFF, Hi=0x00000064; Done at k+2.
- Handshake and reset:
  - Start pulsed at k+5 during a multiply is ignored; the original result is unchanged.
  - Start in the DONE cycle is accepted.
  - Reset_n low at k+7 of a divide -> Busy=0, Done=0, Hi=Lo=0 immediately. A following MULTU 6*7 gives Lo=42.
- With MDU_EARLY_OUT_EN: MULTU 7*3 -> Lo=21, Done at k+3; MULTU 7*0xFFFFFFFF still Done at k+18. Without the macro, 7*3 -> Done at k+18.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// FSM states and iteration-count helpers.
package mdu_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  function automatic int ITER_MUL(input int nbit, input int bpc);
    return nbit / bpc;
  endfunction

  function automatic int ITER_DIV(input int nbit);
    return nbit;
  endfunction

endpackage

// File: rtl/mdu_neg.sv
// Conditional two's-complement negate: result = en ? -value : value.
module mdu_neg #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         en,
  output logic [W-1:0] result
);

  assign result = en ? (~value + W'(1)) : value;

endmodule

// File: rtl/mdu_iterative.sv
// Iterative MULTU/MULT/DIVU/DIV unit with Start/Busy/Done handshake.
// Optional macro MDU_EARLY_OUT_EN ends a multiply once the remaining multiplier bits are zero.
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int NBIT           = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Start,
  input  logic [1:0]      Op,
  input  logic [NBIT-1:0] MA,
  input  logic [NBIT-1:0] MB,
  output logic            Busy,
  output logic            Done,
  output logic [NBIT-1:0] Hi,
  output logic [NBIT-1:0] Lo
);

  localparam int CW = $clog2(NBIT + 1);

  state_t              state, state_nx;
  logic                div_r, div_zero_r, neg_q_r, neg_r_r, done_r;
  logic [2*NBIT-1:0]   a_r, acc_r;
  logic [NBIT-1:0]     b_r, hi_r, lo_r;
  logic [CW-1:0]       cnt_r;

  logic                op_div, op_signed, div_zero, accept, last_iter;
  logic [NBIT-1:0]     mag_a, mag_b, b_nx, quo_fix, rem_fix;
  logic [2*NBIT-1:0]   part, acc_mul_nx, acc_div_nx, prod_fix;
  logic [NBIT:0]       rem_sh, diff;

  assign op_div    = (Op == OP_DIVU) || (Op == OP_DIV);
  assign op_signed = (Op == OP_MULT) || (Op == OP_DIV);
  assign div_zero  = op_div && (MB == '0);
  assign accept    = (state == IDLE) && Start;

  mdu_neg #(.W(NBIT)) u_mag_a (.value(MA), .en(op_signed & MA[NBIT-1]), .result(mag_a));
  mdu_neg #(.W(NBIT)) u_mag_b (.value(MB), .en(op_signed & MB[NBIT-1]), .result(mag_b));

  // Multiply step: shifted multiplicand times the low multiplier digit, added to a full-width accumulator
  always_comb begin
    part = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (b_r[i]) part = part + (a_r << i);
    end
  end
  assign acc_mul_nx = acc_r + part;
  assign b_nx       = b_r >> BITS_PER_CYCLE;

  // Restoring divide step on {remainder, dividend/quotient}
  assign rem_sh = {acc_r[2*NBIT-1:NBIT], acc_r[NBIT-1]};
  assign diff   = rem_sh - {1'b0, b_r};
  assign acc_div_nx = diff[NBIT] ? {rem_sh[NBIT-1:0], acc_r[NBIT-2:0], 1'b0}
                                 : {diff[NBIT-1:0],   acc_r[NBIT-2:0], 1'b1};

  always_comb begin
    last_iter = (cnt_r == CW'(1));
`ifdef MDU_EARLY_OUT_EN
    if (!div_r && (b_nx == '0)) last_iter = 1'b1;
`endif
  end

  mdu_neg #(.W(2*NBIT)) u_prod (.value(acc_r), .en(neg_q_r), .result(prod_fix));
  mdu_neg #(.W(NBIT)) u_quo (.value(acc_r[NBIT-1:0]), .en(neg_q_r), .result(quo_fix));
  mdu_neg #(.W(NBIT)) u_rem (.value(acc_r[2*NBIT-1:NBIT]), .en(neg_r_r), .result(rem_fix));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Start) state_nx = div_zero ? FIX : CALC;
      CALC:    if (last_iter) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_r      <= 1'b0;
      div_zero_r <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      done_r     <= 1'b0;
      a_r        <= '0;
      acc_r      <= '0;
      b_r        <= '0;
      cnt_r      <= '0;
      hi_r       <= '0;
      lo_r       <= '0;
    end else begin
      // The Done pulse trails the DONE state by one edge; IDLE is then already open for a new Start
      done_r <= (state == DONE);
      if (accept) begin
        div_r      <= op_div;
        div_zero_r <= div_zero;
        neg_q_r    <= op_signed & (MA[NBIT-1] ^ MB[NBIT-1]);
        neg_r_r    <= op_signed & MA[NBIT-1];
        b_r        <= mag_b;
        if (op_div) begin
          cnt_r <= CW'(ITER_DIV(NBIT));
          a_r   <= {{NBIT{1'b0}}, MA};
          acc_r <= {{NBIT{1'b0}}, mag_a};
        end else begin
          cnt_r <= CW'(ITER_MUL(NBIT, BITS_PER_CYCLE));
          a_r   <= {{NBIT{1'b0}}, mag_a};
          acc_r <= '0;
        end
      end else if (state == CALC) begin
        cnt_r <= cnt_r - CW'(1);
        if (div_r) begin
          acc_r <= acc_div_nx;
        end else begin
          acc_r <= acc_mul_nx;
          a_r   <= a_r << BITS_PER_CYCLE;
          b_r   <= b_nx;
        end
      end else if (state == FIX) begin
        if (div_zero_r) begin
          hi_r <= a_r[NBIT-1:0];
          lo_r <= '1;
        end else if (div_r) begin
          hi_r <= rem_fix;
          lo_r <= quo_fix;
        end else begin
          hi_r <= prod_fix[2*NBIT-1:NBIT];
          lo_r <= prod_fix[NBIT-1:0];
        end
      end
    end
  end

  assign Busy = (state != IDLE);
  assign Done = done_r;
  assign Hi   = hi_r;
  assign Lo   = lo_r;

endmodule
